// File: rtl/bcd_formatter_if.sv
// CPU-side access port and display-side write port of the BCD formatter.
interface bcd_formatter_if;
  logic        chip_select_i;
  logic [31:0] write_data_i;
  logic [3:0]  write_mask_i;
  logic [31:0] read_data_o;
  logic        dsp_cs_o;
  logic [31:0] dsp_data_o;
  logic [3:0]  dsp_mask_o;

  // Bus owner: drives CPU accesses, observes status and display writes.
  modport master (
    output chip_select_i, write_data_i, write_mask_i,
    input  read_data_o, dsp_cs_o, dsp_data_o, dsp_mask_o
  );

  // Formatter side.
  modport slave (
    input  chip_select_i, write_data_i, write_mask_i,
    output read_data_o, dsp_cs_o, dsp_data_o, dsp_mask_o
  );
endinterface

// File: rtl/bcd_formatter.sv
// Binary-to-BCD formatter: converts a CPU-written word with iterative
// double-dabble and issues one full-word write to the seven-segment display.
module bcd_formatter #(
  parameter logic [31:0] OVERFLOW_PATTERN = 32'hEEEE_EEEE
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bcd_formatter_if.slave bus
);

  localparam int unsigned WordW  = 32;
  localparam int unsigned MaskW  = 4;
  localparam int unsigned BcdW   = 40;
  localparam int unsigned ShiftW = WordW + BcdW;
  localparam int unsigned CntW   = 5;
  localparam int unsigned NibN   = BcdW / 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WordW-1:0]    operand_q, operand_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                busy_q, busy_d;
  logic                pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                dsp_cs_q, dsp_cs_d;
  logic [WordW-1:0]    dsp_data_q, dsp_data_d;
  logic [MaskW-1:0]    dsp_mask_q, dsp_mask_d;

  logic                wr_c;
  logic [WordW-1:0]    merged_c;

  // One double-dabble iteration: correct every BCD nibble, then shift left.
  function automatic logic [ShiftW-1:0] dabble_step(input logic [ShiftW-1:0] s);
    logic [ShiftW-1:0] t;
    logic [3:0]        nib;
    t = s;
    for (int i = 0; i < int'(NibN); i++) begin
      nib = t[WordW + 4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      t[WordW + 4*i +: 4] = nib;
    end
    return {t[ShiftW-2:0], 1'b0};
  endfunction

  // Decode a CPU write and merge the enabled bytes into the operand.
  always_comb begin
    wr_c     = bus.chip_select_i && (bus.write_mask_i != '0);
    merged_c = operand_q;
    for (int b = 0; b < int'(MaskW); b++) begin
      if (bus.write_mask_i[b]) merged_c[8*b +: 8] = bus.write_data_i[8*b +: 8];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    operand_d  = wr_c ? merged_c : operand_q;
    shift_d    = shift_q;
    count_d    = count_q;
    busy_d     = busy_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    dsp_cs_d   = 1'b0;
    dsp_mask_d = '0;
    dsp_data_d = dsp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_c) begin
          shift_d = {BcdW'(0), merged_c};
          count_d = '0;
          busy_d  = 1'b1;
          state_d = ST_CONVERT;
        end
      end

      ST_CONVERT: begin
        shift_d = dabble_step(shift_q);
        count_d = count_q + CntW'(1);
        if (wr_c) pending_d = 1'b1;
        if (count_q == '1) state_d = ST_EMIT;
      end

      ST_EMIT: begin
        dsp_cs_d   = 1'b1;
        dsp_mask_d = '1;
        if (shift_q[ShiftW-1 -: 8] != '0) begin
          dsp_data_d = OVERFLOW_PATTERN;
          overflow_d = 1'b1;
        end else begin
          dsp_data_d = shift_q[ShiftW-9 -: WordW];
          overflow_d = 1'b0;
        end
        // A request pending or arriving now restarts straight from the merged operand.
        pending_d = 1'b0;
        if (pending_q || wr_c) begin
          shift_d = {BcdW'(0), operand_d};
          count_d = '0;
          state_d = ST_CONVERT;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      operand_q  <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      dsp_cs_q   <= 1'b0;
      dsp_data_q <= '0;
      dsp_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      operand_q  <= operand_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      dsp_cs_q   <= dsp_cs_d;
      dsp_data_q <= dsp_data_d;
      dsp_mask_q <= dsp_mask_d;
    end
  end

  assign bus.read_data_o = {30'b0, overflow_q, busy_q};
  assign bus.dsp_cs_o    = dsp_cs_q;
  assign bus.dsp_data_o  = dsp_data_q;
  assign bus.dsp_mask_o  = dsp_mask_q;

endmodule

// File: doc/bcd_formatter.md
# bcd_formatter

Memory-mapped binary-to-BCD converter that sits directly upstream of the seven-segment display peripheral. Software writes a binary word to it. The block converts that word to eight packed BCD digits using iterative double-dabble, then issues a single full-word write on the display's read/write port so the display shows the value in decimal. Values that do not fit in eight decimal digits are replaced by a fixed overflow pattern.

## Interface
Parameters:
- OVERFLOW_PATTERN, default 32'hEEEE_EEEE: word written to the display when the value exceeds 99_999_999.

Ports:
- clk_i, input, 1: system clock. Single clock domain.
- rst_ni, input, 1: reset, asynchronous assert, active-low.
- chip_select_i, input, 1: CPU-side access strobe.
- write_data_i, input, 32 (word_t): CPU write data.
- write_mask_i, input, 4: byte enables. Bit n covers byte n. A mask of 4'h0 means a read.
- read_data_o, output, 32 (word_t): status word {30'b0, overflow_r, busy_r}. Combinational from registers.
- dsp_cs_o, output, 1: display chip select. One-cycle pulse.
- dsp_data_o, output, 32 (word_t): packed BCD to the display, digit 0 in [3:0].
- dsp_mask_o, output, 4: display byte mask. 4'hF whenever dsp_cs_o=1, otherwise 4'h0.

## Operation
- The operand register operand_r is 32 bits. A write is any cycle with chip_select_i=1 and write_mask_i≠0.
- On a write, each byte whose mask bit is set merges into operand_r. Other bytes are kept.
- Every write requests a conversion of the merged operand_r.
- FSM states: IDLE, CONVERT, EMIT.
- IDLE, on a write: load shift_r (72 bits) = {40'b0, merged operand}, set count_r=0, set busy_r=1, go to CONVERT.
- CONVERT, each cycle:
  - For each of the 10 BCD nibbles in shift_r[71:32], add 3 if the nibble is ≥5.
  - Then shift the whole 72-bit value left by 1.
  - Increment count_r (5 bits).
  - When count_r=31, go to EMIT.
- EMIT, one cycle:
  - Register the result: dsp_cs_o=1, dsp_mask_o=4'hF.
  - If the upper two BCD digits are non-zero, set dsp_data_o=OVERFLOW_PATTERN and overflow_r=1.
  - Otherwise set dsp_data_o=BCD[31:0] and overflow_r=0.
  - If pending_r=1: clear pending_r, reload shift_r from operand_r, set count_r=0, go to CONVERT with busy_r still 1.
  - If pending_r=0: clear busy_r, go to IDLE.
- Write while busy_r=1 (CONVERT or EMIT):
  - operand_r merges as usual and pending_r is set.
  - The in-flight conversion is not disturbed.
  - Multiple writes coalesce into one pending request. Only the final operand_r value is converted.
- A write in the same cycle that EMIT consumes pending_r: the merged operand is the value loaded into shift_r, and pending_r stays 0.
- Reads have no side effects.
- Reset values:
  - Outputs: dsp_cs_o=0, dsp_data_o=0, dsp_mask_o=0, read_data_o=0.
  - Internal: operand_r=0, shift_r=0, count_r=0, busy_r=0, pending_r=0, overflow_r=0, state IDLE.
- Reset asserted mid-conversion aborts it. No display write is issued and the pending request is lost.

## Timing
- Write sampled at edge E0. busy_r reads 1 from after E0.
- Shift iterations occur at edges E1..E32.
- EMIT registers load at edge E33. dsp_cs_o is high for exactly the cycle E33→E34.
- busy_r clears at E33 unless a request is pending.
- Latency from write to display strobe: 33 clocks.
- Back-to-back conversions: successive strobes are 33 clocks apart.
- dsp_data_o holds its value after the strobe until the next EMIT.
- dsp_cs_o is never high on two consecutive cycles.
- The display samples on the strobe cycle, so it sees exactly one write per conversion.
- All outputs are registered. There is no combinational path from CPU inputs to the display outputs.

## Test plan
- Write 32'd12345678 with mask 4'hF at E0. Required: dsp_cs_o pulses at E33 only, with dsp_data_o=32'h1234_5678, dsp_mask_o=4'hF, and afterwards read_data_o=32'h0.
- Boundary values:
  - 32'd99999999 → 32'h9999_9999, overflow 0.
  - 32'd100000000 → 32'hEEEE_EEEE, read_data_o=32'h2.
  - 32'hFFFF_FFFF → 32'hEEEE_EEEE.
  - 0 → 32'h0000_0000.
- Byte merge: after reset, write mask 4'b0001 with data 32'h0000_00FF → 32'h0000_0255. Then write mask 4'b0010 with data 32'h0000_0100 → operand 0x1FF → 32'h0000_0511.
- Writes while busy:
  - Write 1 at E0, write 2 at E10, write 3 at E20. Required: strobes with 32'h1 at E33 and 32'h3 at E66, then no third strobe.
  - Write 7 exactly at E33. Required: strobe 32'h7 at E66.
- Reset mid-operation: write 5, assert rst_ni low at E15 for 2 cycles. Required: all outputs 0 immediately on assert, no strobe afterward, read_data_o=0.
- Status polling: during a conversion, read_data_o[0]=1 on every cycle from E0+ through E32. Reads with mask 4'h0 never start a conversion.
